uart_packet_bridge: RTL and testbench

//   Parametrised packet bridge between the byte-level UART core and a compute core.
//   - Assembles IN_BYTES received bytes into one request word and hands it over with a valid/ready handshake.
//   - Takes back one OUT_BYTES response word and serialises it to the UART transmitter.
//   - Adds inter-byte timeout resync, error reporting and an optional XOR checksum.

---
 rtl/uart_packet_bridge.sv | 179 +++++++++++++++++
 tb/tb_uart_packet_bridge.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_bridge.sv
// Byte-stream <-> word bridge: gathers IN_BYTES rx bytes into a request, serialises an OUT_BYTES response to the UART.
// Define UART_PKT_CHECKSUM_EN to append/verify a trailing XOR checksum byte on both directions.
module uart_packet_bridge #(
  parameter int IN_BYTES       = 6,
  parameter int OUT_BYTES      = 8,
  parameter int TIMEOUT_CYCLES = 125000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_error,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [7:0]             tx_byte,
  output logic                   req_valid,
  output logic [IN_BYTES*8-1:0]  req_data,
  input  logic                   req_ready,
  input  logic                   rsp_valid,
  input  logic [OUT_BYTES*8-1:0] rsp_data,
  output logic                   rsp_ready,
  output logic                   frame_err,
  output logic                   busy
);

`ifdef UART_PKT_CHECKSUM_EN
  localparam int RX_LEN = IN_BYTES + 1;
  localparam int TX_LEN = OUT_BYTES + 1;
`else
  localparam int RX_LEN = IN_BYTES;
  localparam int TX_LEN = OUT_BYTES;
`endif
  localparam int MAX_LEN = (RX_LEN > TX_LEN) ? RX_LEN : TX_LEN;
  localparam int CW      = $clog2(MAX_LEN + 2);
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW      = IN_BYTES * 8;
  localparam int OW      = OUT_BYTES * 8;
  localparam int SW      = TX_LEN * 8;

  localparam logic [2:0] S_RECV     = 3'd0;
  localparam logic [2:0] S_REQ      = 3'd1;
  localparam logic [2:0] S_RSP      = 3'd2;
  localparam logic [2:0] S_TX_LOAD  = 3'd3;
  localparam logic [2:0] S_TX_START = 3'd4;
  localparam logic [2:0] S_TX_WAIT  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [IW-1:0] req_q, req_d;
  logic [SW-1:0] sh_q, sh_d;
  logic [CW-1:0] sent_q, sent_d;
  logic          ferr_q, ferr_d;

`ifdef UART_PKT_CHECKSUM_EN
  logic [7:0]    rx_xor_q, rx_xor_d;

  function automatic logic [7:0] xor_bytes(input logic [OW-1:0] w);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < OUT_BYTES; i++) x = x ^ w[i*8 +: 8];
    return x;
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    rx_cnt_d = rx_cnt_q;
    to_d     = to_q;
    req_d    = req_q;
    sh_d     = sh_q;
    sent_d   = sent_q;
    ferr_d   = 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
    rx_xor_d = rx_xor_q;
`endif
    case (state_q)
      S_RECV: begin
        // An error strobe beats a coincident byte: the whole partial frame is dropped.
        if (rx_error) begin
          rx_cnt_d = '0;
          to_d     = '0;
          ferr_d   = 1'b1;
        end else if (rx_valid) begin
          to_d     = '0;
          rx_cnt_d = rx_cnt_q + CW'(1);
`ifdef UART_PKT_CHECKSUM_EN
          if (rx_cnt_q == CW'(IN_BYTES)) begin
            rx_cnt_d = '0;
            if (rx_byte == rx_xor_q) state_d = S_REQ;
            else                     ferr_d  = 1'b1;
          end else begin
            req_d    = (req_q << 8) | IW'(rx_byte);
            rx_xor_d = (rx_cnt_q == '0) ? rx_byte : (rx_xor_q ^ rx_byte);
          end
`else
          req_d = (req_q << 8) | IW'(rx_byte);
          if (rx_cnt_q == CW'(RX_LEN - 1)) begin
            rx_cnt_d = '0;
            state_d  = S_REQ;
          end
`endif
        end else if (rx_cnt_q != '0) begin
          if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
            rx_cnt_d = '0;
            to_d     = '0;
            ferr_d   = 1'b1;
          end else begin
            to_d = to_q + TW'(1);
          end
        end
      end
      S_REQ: begin
        if (req_ready) state_d = S_RSP;
      end
      S_RSP: begin
        if (rsp_valid) begin
`ifdef UART_PKT_CHECKSUM_EN
          sh_d = {rsp_data, xor_bytes(rsp_data)};
`else
          sh_d = rsp_data;
`endif
          sent_d  = '0;
          state_d = S_TX_LOAD;
        end
      end
      S_TX_LOAD: begin
        if (!tx_busy) state_d = S_TX_START;
      end
      S_TX_START: begin
        if (tx_busy) state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (!tx_busy) begin
          sh_d   = sh_q << 8;
          sent_d = sent_q + CW'(1);
          state_d = (sent_q == CW'(TX_LEN - 1)) ? S_RECV : S_TX_LOAD;
        end
      end
      default: state_d = S_RECV;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RECV;
      rx_cnt_q <= '0;
      to_q     <= '0;
      req_q    <= '0;
      sh_q     <= '0;
      sent_q   <= '0;
      ferr_q   <= 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
      rx_xor_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rx_cnt_q <= rx_cnt_d;
      to_q     <= to_d;
      req_q    <= req_d;
      sh_q     <= sh_d;
      sent_q   <= sent_d;
      ferr_q   <= ferr_d;
`ifdef UART_PKT_CHECKSUM_EN
      rx_xor_q <= rx_xor_d;
`endif
    end
  end

  // tx_start is decoded from state so it falls the instant reset is applied.
  assign tx_start  = (state_q == S_TX_LOAD) && !tx_busy;
  assign tx_byte   = sh_q[SW-1 -: 8];
  assign req_valid = (state_q == S_REQ);
  assign req_data  = req_q;
  assign rsp_ready = (state_q == S_RSP);
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_RECV);

endmodule

// File: tb/tb_uart_packet_bridge.sv
// Scoreboard bench for uart_packet_bridge with a simple UART transmitter model.
module tb_uart_packet_bridge;
  localparam int TO = 50;
`ifdef UART_PKT_CHECKSUM_EN
  localparam int TXN = 9;
`else
  localparam int TXN = 8;
`endif

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_error;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        req_valid;
  logic [47:0] req_data;
  logic        req_ready;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_ready;
  logic        frame_err;
  logic        busy;

  uart_packet_bridge #(.IN_BYTES(6), .OUT_BYTES(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_error(rx_error),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tx_pulses = 0;
  logic [47:0] req_exp[$];
  logic [7:0]  tx_exp[$];
  int          ferr_exp[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Request monitor
  initial forever begin
    @(negedge clk);
    if (req_valid && req_ready) begin
      check("req_expected", 64'(req_exp.size() > 0), 64'd1);
      if (req_exp.size() > 0) check("req_data", 64'(req_data), 64'(req_exp.pop_front()));
    end
  end

  // frame_err monitor
  initial forever begin
    @(negedge clk);
    if (frame_err) begin
      check("frame_err_expected", 64'(ferr_exp.size() > 0), 64'd1);
      if (ferr_exp.size() > 0) void'(ferr_exp.pop_front());
    end
  end

  // UART transmitter model + tx byte checker
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        tx_pulses++;
        check("tx_expected", 64'(tx_exp.size() > 0), 64'd1);
        if (tx_exp.size() > 0) check("tx_byte", 64'(tx_byte), 64'(tx_exp.pop_front()));
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat (4) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] w, input bit expect_req);
    logic [7:0] x;
    x = '0;
    if (expect_req) req_exp.push_back(w);
    for (int i = 0; i < 6; i++) begin
      x = x ^ w[47-8*i -: 8];
      send_byte(w[47-8*i -: 8]);
    end
`ifdef UART_PKT_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic send_rsp(input logic [63:0] d);
    logic [7:0] x;
    bit got;
    x = '0;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      tx_exp.push_back(d[63-8*i -: 8]);
      x = x ^ d[63-8*i -: 8];
    end
`ifdef UART_PKT_CHECKSUM_EN
    tx_exp.push_back(x);
`endif
    rsp_valid = 1'b1; rsp_data = d;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (rsp_ready) got = 1;
    end
    check("rsp_ready_seen", 64'(got), 64'd1);
    @(posedge clk); #1 rsp_valid = 1'b0;
    @(negedge clk);
    check("rsp_to_tx_start_latency", 64'(tx_start), 64'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    check("idle_reached", 64'(done), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_byte = '0; rx_error = 1'b0;
    req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_tx_byte", 64'(tx_byte), 64'd0);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_req_data", 64'(req_data), 64'd0);
    check("rst_rsp_ready", 64'(rsp_ready), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // 1: basic round trip
    tx_pulses = 0;
    send_frame(48'h010203040506, 1'b1);
    @(negedge clk);
    check("rx_to_req_latency", 64'(req_valid), 64'd1);
    send_rsp(64'hA0A1A2A3A4A5A6A7);
    wait_idle();
    check("t1_tx_pulses", 64'(tx_pulses), 64'(TXN));

    // 2: inter-byte timeout then a clean frame
    ferr_exp.push_back(2);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
    repeat (TO + 20) @(posedge clk);
    check("t2_ferr_consumed", 64'(ferr_exp.size()), 64'd0);
    send_frame(48'h111213141516, 1'b1);
    send_rsp(64'h0123456789ABCDEF);
    wait_idle();

    // 3: rx_error mid-frame, error+byte same cycle, bytes ignored during tx
    send_byte(8'h90); send_byte(8'h91);
    ferr_exp.push_back(3);
    @(posedge clk); #1 rx_error = 1'b1;
    @(posedge clk); #1 rx_error = 1'b0;
    send_byte(8'h92);
    ferr_exp.push_back(3);
    @(posedge clk); #1 rx_error = 1'b1; rx_valid = 1'b1; rx_byte = 8'h93;
    @(posedge clk); #1 rx_error = 1'b0; rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    check("t3_ferr_consumed", 64'(ferr_exp.size()), 64'd0);
    send_frame(48'h212223242526, 1'b1);
    send_rsp(64'h1020304050607080);
    for (int i = 0; i < 3; i++) begin
      check("t3_busy_during_tx", 64'(busy), 64'd1);
      send_byte(8'hEE);
    end
    wait_idle();
    send_frame(48'h313233343536, 1'b1);
    send_rsp(64'h8877665544332211);
    wait_idle();

    // 4: request backpressure; early response held off
    req_ready = 1'b0;
    send_frame(48'hC1C2C3C4C5C6, 1'b1);
    rsp_valid = 1'b1; rsp_data = 64'hDEADBEEFCAFEF00D;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t4_req_valid_held", 64'(req_valid), 64'd1);
      check("t4_req_data_stable", 64'(req_data), 64'h0000C1C2C3C4C5C6);
      check("t4_rsp_ready_low", 64'(rsp_ready), 64'd0);
    end
    @(posedge clk); #1 req_ready = 1'b1;
    send_rsp(64'hDEADBEEFCAFEF00D);
    wait_idle();

    // 5: reset while the 4th response byte is being launched
    tx_pulses = 0;
    send_frame(48'h414243444546, 1'b1);
    send_rsp(64'hB0B1B2B3B4B5B6B7);
    for (int i = 0; i < 500 && tx_pulses < 4; i++) begin
      @(negedge clk); #1;
    end
    check("t5_reached_4th_byte", 64'(tx_pulses), 64'd4);
    check("t5_tx_start_before_rst", 64'(tx_start), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_tx_start_async", 64'(tx_start), 64'd0);
    check("t5_busy_async", 64'(busy), 64'd0);
    check("t5_tx_byte_async", 64'(tx_byte), 64'd0);
    check("t5_remaining_tx", 64'(tx_exp.size()), 64'(TXN - 4));
    tx_exp.delete();
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    send_frame(48'h515253545556, 1'b1);
    send_rsp(64'hC0C1C2C3C4C5C6C7);
    wait_idle();

`ifdef UART_PKT_CHECKSUM_EN
    // 6: checksum accept and reject
    tx_pulses = 0;
    send_frame(48'h010203040506, 1'b1);
    send_rsp(64'hA0A1A2A3A4A5A6A7);
    wait_idle();
    check("t6_tx_pulses", 64'(tx_pulses), 64'd9);
    ferr_exp.push_back(6);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    send_byte(8'h00);
    repeat (3) @(posedge clk);
    check("t6_ferr_consumed", 64'(ferr_exp.size()), 64'd0);
    check("t6_no_req", 64'(req_valid), 64'd0);
`endif

    repeat (5) @(posedge clk);
    check("end_req_queue_empty", 64'(req_exp.size()), 64'd0);
    check("end_tx_queue_empty", 64'(tx_exp.size()), 64'd0);
    check("end_ferr_queue_empty", 64'(ferr_exp.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
